delay_monitor: RTL and testbench
================================

# delay_monitor

Synchronous response-side measurement block for gate-delay characterisation. The stimulus side applies input vectors to a combinational circuit under test (CUT) and pulses `launch`. This block samples the CUT output and reports, per vector, the settling delay in clock cycles, the number of output transitions (hazard/glitch count) and a timeout flag. It also keeps running min/max delay statistics.

## Interface
- `CNT_W`, 8: width of cycle counter, `delay`, `min_delay`, `max_delay`
- `EDGE_W`, 4: width of transition counter `edges`
- `SETTLE`, 2: extra consecutive matching samples required after first match (≥1)
- `TIMEOUT`, 200: cycle count at which a measurement is abandoned (< 2^CNT_W − 1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `launch`  in  1  one-cycle pulse: stimulus applied, start measurement
- `expected`  in  1  expected settled value of CUT output; sampled with `launch`
- `F_in`  in  1  CUT output, asynchronous to `clk`
- `clr_stats`  in  1  synchronous clear of `min_delay`/`max_delay`
- `busy`  out  1  measurement in progress
- `done`  out  1  one-cycle pulse: successful measurement
- `timeout`  out  1  one-cycle pulse: measurement abandoned
- `delay`  out  CNT_W  last measured delay; all-ones after timeout
- `edges`  out  EDGE_W  transitions of synchronized F during last measurement, saturating
- `min_delay`  out  CNT_W  minimum successful delay since reset/clear
- `max_delay`  out  CNT_W  maximum successful delay since reset/clear

## Operation
- `F_in` passes through a 2-flop synchronizer. `F_s` is the second stage, and all comparisons use `F_s`. `F_p` holds the previous `F_s` for edge detection.
- States: IDLE, MEASURE, STABLE.
- IDLE: when `launch`=1, latch `expected`, clear `cnt`, `edges` and `stab`, then go to MEASURE.
- MEASURE: each edge, `cnt` increments, saturating at 2^CNT_W − 1. If `F_s`==exp, capture `match_cnt`=current `cnt`, set `stab`=0 and go to STABLE.
- STABLE: each edge, `cnt` increments. If `F_s`!=exp, return to MEASURE. Otherwise `stab`++. When `stab` reaches SETTLE−1 on a matching sample:
  - `delay`=`match_cnt` and `done` pulses.
  - Stats update: `min_delay`=min(`min_delay`,`delay`), `max_delay`=max(`max_delay`,`delay`).
  - Go to IDLE.
- In MEASURE and STABLE, `edges` increments (saturating at 2^EDGE_W − 1) on every cycle with `F_s`!=`F_p`.
- Timeout: in MEASURE or STABLE, when `cnt`==TIMEOUT−1 and completion does not occur that edge, then `timeout` pulses, `delay`=all-ones, stats are unchanged and the state goes to IDLE.
- `launch` while in MEASURE or STABLE aborts the current measurement with no `done` and no `timeout`, then restarts: `cnt`, `edges` and `stab` are cleared and `expected` is re-latched. If `launch` arrives on the same edge as a completion or timeout, `launch` wins and nothing is reported.
- `clr_stats`: `min_delay`=all-ones, `max_delay`=0. If it coincides with `done`, the clear wins.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE; `busy`, `done`, `timeout` = 0; `delay` = 0; `edges` = 0; `min_delay` = all-ones; `max_delay` = 0; synchronizer flops = 0.
- Launch sampled at edge L gives `cnt`=j after edge L+j. A comparison at edge L+j+1 uses `cnt`=j.
- `F_in` changing between edges L+k and L+k+1 (k ≥ 0) and then holding gives `delay` = k+2. The +2 is synchronizer latency and is included by definition.
- `F_s` already equal to `expected` at launch gives `delay` = 0.
- `done` is asserted in the cycle after edge L+`delay`+SETTLE+1. `delay`, `edges` and stats are valid in that same cycle and hold until the next completion or timeout.
- `timeout` is asserted in the cycle after edge L+TIMEOUT.
- Reset mid-measurement: immediate return to reset values, with no pulse.

## Test plan
- Clean rise: `expected`=1; `F_in` 0→1 at k=5. Required: `delay`=7, `edges`=1; `done` one cycle after edge L+10 (SETTLE=2); `min_delay`=`max_delay`=7.
- Glitch: `expected`=1; `F_in` 0→1 at k=2, 1→0 at k=3, 0→1 at k=6. Required: `delay`=8, `edges`=3, one `done` only.
- Already settled: `F_in`=0 held, `expected`=0. Required: `delay`=0, `edges`=0, `done` after edge L+3.
- Timeout: `expected`=1, `F_in` stuck 0, TIMEOUT=200. Required: `timeout` after edge L+200, `delay`=255, stats unchanged, `busy`=0.
- Re-launch: second `launch` at L+3 during a pending measurement; `F_in` settles at k=4 relative to the new launch. Required: a single `done` with `delay`=6; over runs of 7 then 6, `min_delay`=6 and `max_delay`=7.
- Async reset asserted during STABLE. Required: all outputs at reset values immediately, with no `done`. Then `clr_stats` → `min_delay`=255, `max_delay`=0.

Source files
------------

// File: rtl/delay_monitor_if.sv
// Stimulus/response bundle between the launch side and the delay monitor.
interface delay_monitor_if #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned EDGE_W = 4
);
    logic              launch;
    logic              expected;
    logic              F_in;
    logic              clr_stats;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  delay;
    logic [EDGE_W-1:0] edges;
    logic [CNT_W-1:0]  min_delay;
    logic [CNT_W-1:0]  max_delay;

    modport master (
        output launch, expected, F_in, clr_stats,
        input  busy, done, timeout, delay, edges, min_delay, max_delay
    );

    modport slave (
        input  launch, expected, F_in, clr_stats,
        output busy, done, timeout, delay, edges, min_delay, max_delay
    );
endinterface

// File: rtl/delay_monitor.sv
// Measures CUT output settling delay, glitch count and timeout per launched
// vector, and tracks min/max settling delay across successful runs.
module delay_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned EDGE_W  = 4,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    delay_monitor_if.slave mon
);
    localparam int unsigned STAB_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [EDGE_W-1:0] EDGE_MAX = '1;
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_END = STAB_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, STABLE} state_t;

    state_t            state, state_nxt;
    logic              f_meta, f_s, f_p;
    logic              exp_q, exp_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  match_cnt, match_nxt;
    logic [STAB_W-1:0] stab, stab_nxt;
    logic [EDGE_W-1:0] edge_cnt, edge_nxt;
    logic [CNT_W-1:0]  delay_q, delay_nxt;
    logic [EDGE_W-1:0] edges_q, edges_nxt;
    logic [CNT_W-1:0]  min_q, min_nxt;
    logic [CNT_W-1:0]  max_q, max_nxt;
    logic              done_q, done_nxt;
    logic              timeout_q, timeout_nxt;
    logic              busy_q, busy_nxt;
    logic              match;
    logic              finish;

    // Two-flop synchronizer plus previous-sample stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_meta <= 1'b0;
            f_s    <= 1'b0;
            f_p    <= 1'b0;
        end else begin
            f_meta <= mon.F_in;
            f_s    <= f_meta;
            f_p    <= f_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_q     <= 1'b0;
            cnt       <= '0;
            match_cnt <= '0;
            stab      <= '0;
            edge_cnt  <= '0;
            delay_q   <= '0;
            edges_q   <= '0;
            min_q     <= '1;
            max_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_q     <= exp_nxt;
            cnt       <= cnt_nxt;
            match_cnt <= match_nxt;
            stab      <= stab_nxt;
            edge_cnt  <= edge_nxt;
            delay_q   <= delay_nxt;
            edges_q   <= edges_nxt;
            min_q     <= min_nxt;
            max_q     <= max_nxt;
            done_q    <= done_nxt;
            timeout_q <= timeout_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Launch restarts from any state and suppresses a coincident report.
    always_comb begin
        state_nxt   = state;
        exp_nxt     = exp_q;
        cnt_nxt     = cnt;
        match_nxt   = match_cnt;
        stab_nxt    = stab;
        edge_nxt    = edge_cnt;
        delay_nxt   = delay_q;
        edges_nxt   = edges_q;
        min_nxt     = min_q;
        max_nxt     = max_q;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        match       = (f_s == exp_q);
        finish      = 1'b0;

        if (mon.launch) begin
            state_nxt = MEASURE;
            exp_nxt   = mon.expected;
            cnt_nxt   = '0;
            stab_nxt  = '0;
            edge_nxt  = '0;
        end else if (state != IDLE) begin
            if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            if ((f_s != f_p) && (edge_cnt != EDGE_MAX)) begin
                edge_nxt = edge_cnt + EDGE_W'(1);
            end

            if (state == MEASURE) begin
                if (match) begin
                    match_nxt = cnt;
                    stab_nxt  = '0;
                    state_nxt = STABLE;
                end
            end else if (!match) begin
                state_nxt = MEASURE;
            end else if (stab == STAB_END) begin
                finish = 1'b1;
            end else begin
                stab_nxt = stab + STAB_W'(1);
            end

            // Completion takes priority over a timeout on the same edge.
            if (finish) begin
                delay_nxt = match_cnt;
                edges_nxt = edge_nxt;
                min_nxt   = (match_cnt < min_q) ? match_cnt : min_q;
                max_nxt   = (match_cnt > max_q) ? match_cnt : max_q;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end else if (cnt == TO_LAST) begin
                delay_nxt   = '1;
                edges_nxt   = edge_nxt;
                timeout_nxt = 1'b1;
                state_nxt   = IDLE;
            end
        end

        if (mon.clr_stats) begin
            min_nxt = '1;
            max_nxt = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    assign mon.busy      = busy_q;
    assign mon.done      = done_q;
    assign mon.timeout   = timeout_q;
    assign mon.delay     = delay_q;
    assign mon.edges     = edges_q;
    assign mon.min_delay = min_q;
    assign mon.max_delay = max_q;
endmodule

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor: scoreboarded results checked on done/timeout.
module tb_delay_monitor;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned EDGE_W  = 4;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 200;

    typedef struct {
        bit          to;
        int unsigned dly;
        int unsigned edg;
        int unsigned mn;
        int unsigned mx;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sb[$];

    delay_monitor_if #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) bus ();

    delay_monitor #(
        .CNT_W(CNT_W), .EDGE_W(EDGE_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard whenever the DUT reports a result.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done || bus.timeout) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'({bus.done, bus.timeout}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("kind_done",    32'(bus.done),      32'(!e.to));
                check("kind_timeout", 32'(bus.timeout),   32'(e.to));
                check("report_cycle", cyc,                e.cyc);
                check("delay",        32'(bus.delay),     e.dly);
                check("edges",        32'(bus.edges),     e.edg);
                check("min_delay",    32'(bus.min_delay), e.mn);
                check("max_delay",    32'(bus.max_delay), e.mx);
                check("busy_at_end",  32'(bus.busy),      32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; launch is sampled at the following edge L.
    task automatic start(input logic e, input bit push, input bit to,
                         input int unsigned d, input int unsigned ed,
                         input int unsigned mn, input int unsigned mx);
        exp_t x;
        int unsigned l;
        l = cyc + 1;
        bus.launch   = 1'b1;
        bus.expected = e;
        if (push) begin
            x.to  = to;
            x.dly = d;
            x.edg = ed;
            x.mn  = mn;
            x.mx  = mx;
            x.cyc = to ? (l + TIMEOUT) : (l + d + SETTLE + 1);
            sb.push_back(x);
        end
        @(negedge clk);
        bus.launch = 1'b0;
        check("busy_after_launch", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size() == 0 && !bus.busy), 32'd1);
    endtask

    task automatic f_low();
        bus.F_in = 1'b0;
        tick(4);
    endtask

    initial begin
        bus.launch    = 1'b0;
        bus.expected  = 1'b0;
        bus.F_in      = 1'b0;
        bus.clr_stats = 1'b0;
        tick(3);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_done",    32'(bus.done),      32'd0);
        check("rst_timeout", 32'(bus.timeout),   32'd0);
        check("rst_delay",   32'(bus.delay),     32'd0);
        check("rst_edges",   32'(bus.edges),     32'd0);
        check("rst_min",     32'(bus.min_delay), 32'd255);
        check("rst_max",     32'(bus.max_delay), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Clean rise at k=5.
        start(1'b1, 1'b1, 1'b0, 7, 1, 7, 7);
        tick(5);
        bus.F_in = 1'b1;
        wait_idle("clean_rise_drained");
        f_low();

        // Re-launch at L+3; new run settles at k=4.
        start(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        tick(2);
        start(1'b1, 1'b1, 1'b0, 6, 1, 6, 7);
        tick(4);
        bus.F_in = 1'b1;
        wait_idle("relaunch_drained");
        f_low();

        // Glitching output: rise k=2, fall k=3, rise k=6.
        start(1'b1, 1'b1, 1'b0, 8, 3, 6, 8);
        tick(2);
        bus.F_in = 1'b1;
        tick(1);
        bus.F_in = 1'b0;
        tick(3);
        bus.F_in = 1'b1;
        wait_idle("glitch_drained");
        f_low();

        // Output already at expected value.
        start(1'b0, 1'b1, 1'b0, 0, 0, 0, 8);
        wait_idle("settled_drained");

        // Stuck output: timeout, stats unchanged.
        start(1'b1, 1'b1, 1'b1, 255, 0, 0, 8);
        wait_idle("timeout_drained");

        // Async reset while in STABLE.
        start(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        tick(2);
        bus.F_in = 1'b1;
        tick(4);
        check("stable_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  32'(bus.busy),      32'd0);
        check("midrst_done",  32'(bus.done),      32'd0);
        check("midrst_delay", 32'(bus.delay),     32'd0);
        check("midrst_edges", 32'(bus.edges),     32'd0);
        check("midrst_min",   32'(bus.min_delay), 32'd255);
        check("midrst_max",   32'(bus.max_delay), 32'd0);
        tick(2);
        bus.F_in = 1'b0;
        rst_n = 1'b1;
        tick(4);

        // Rebuild stats, then clear them.
        start(1'b1, 1'b1, 1'b0, 7, 1, 7, 7);
        tick(5);
        bus.F_in = 1'b1;
        wait_idle("post_reset_drained");
        bus.clr_stats = 1'b1;
        tick(1);
        bus.clr_stats = 1'b0;
        tick(1);
        check("clr_min", 32'(bus.min_delay), 32'd255);
        check("clr_max", 32'(bus.max_delay), 32'd0);
        check("clr_delay_held", 32'(bus.delay), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
